// File: rtl/taxi_pkg.sv
// Shared types and constants for the taxi fare meter trip sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: trip state encoding, default unit constants and the
// counter-width helper used by every modulo counter in the block.
package taxi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HOLD = 2'b11
    } trip_state_t;

    localparam int unsigned PULSES_PER_UNIT_DEF = 100;
    localparam int unsigned IDLE_SECS_DEF       = 5;
    localparam int unsigned WAIT_UNIT_SECS_DEF  = 60;
    localparam int unsigned TRIP_SECS_W         = 16;

    // Bits needed to hold the values 0..n-1; at least one bit so a
    // modulus of 1 still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trip_ctrl_if.sv
// Signal bundle between the trip sequencer and its surroundings.
// Latency: n/a (wires only).
// Backpressure: none; all signals are single-cycle strobes or levels.
//
// master: drives buttons, wheel/second strobes and fare_max; sees outputs.
// slave : the trip_ctrl side.
interface trip_ctrl_if;
    import taxi_pkg::*;

    logic                   start_btn;
    logic                   stop_btn;
    logic                   wheel_pulse;
    logic                   sec_tick;
    logic                   fare_max;
    logic [1:0]             state;
    logic                   fare_clr;
    logic                   dist_inc;
    logic                   wait_inc;
    logic [TRIP_SECS_W-1:0] trip_secs;

    modport master (
        output start_btn, stop_btn, wheel_pulse, sec_tick, fare_max,
        input  state, fare_clr, dist_inc, wait_inc, trip_secs
    );

    modport slave (
        input  start_btn, stop_btn, wheel_pulse, sec_tick, fare_max,
        output state, fare_clr, dist_inc, wait_inc, trip_secs
    );

endinterface

// File: rtl/trip_ctrl_mod_counter.sv
// Modulo-N event counter with synchronous clear and registered terminal pulse.
// Latency: term is high one cycle after the enable that completes a unit.
// Backpressure: none; one event per cycle accepted without loss.
//
// Ports: clk/rst_n; en counts one event; clr zeroes the count and wins over
// en; term_en qualifies the terminal pulse without stopping the count.
module mod_counter
    import taxi_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = cnt_width(N)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic term_en,
    output logic term
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         term_q, term_d;

    always_comb begin
        cnt_d  = cnt_q;
        term_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d  = '0;
                term_d = term_en;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign term = term_q;

endmodule

// File: rtl/trip_ctrl.sv
// Taxi trip sequencer: trip state, fare clear and distance/waiting unit strobes.
// Latency: every output is registered, one cycle after the sampled input.
// Backpressure: none; wheel pulses on every cycle are counted without loss.
//
// Ports: clk, rst_n (async active-low); bus (trip_ctrl_if.slave) carries
// start/stop buttons, wheel_pulse, sec_tick, fare_max in and
// state, fare_clr, dist_inc, wait_inc, trip_secs out.
module trip_ctrl
    import taxi_pkg::*;
#(
    parameter int unsigned PULSES_PER_UNIT = PULSES_PER_UNIT_DEF,
    parameter int unsigned IDLE_SECS       = IDLE_SECS_DEF,
    parameter int unsigned WAIT_UNIT_SECS  = WAIT_UNIT_SECS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    trip_ctrl_if.slave  bus
);

    localparam int unsigned      NM_W    = cnt_width(IDLE_SECS);
    localparam logic [NM_W-1:0]  NM_LAST = NM_W'(IDLE_SECS - 1);

    trip_state_t              state_q, state_d;
    logic [NM_W-1:0]          nm_q, nm_d;
    logic [TRIP_SECS_W-1:0]   trip_secs_q, trip_secs_d;
    logic                     fare_clr_q, fare_clr_d;

    logic in_trip;
    logic start_ev;
    logic nm_done;
    logic dist_en;
    logic wait_en;
    logic wait_clr;
    logic dist_term;
    logic wait_term;

    // A new trip only starts from IDLE or HOLD, and a simultaneous stop
    // always takes priority over start.
    assign in_trip  = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign start_ev = bus.start_btn && !bus.stop_btn &&
                      ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign nm_done  = (state_q == ST_RUN) && bus.sec_tick &&
                      !bus.wheel_pulse && (nm_q == NM_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ev) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bus.stop_btn)  state_d = ST_HOLD;
                else if (nm_done)  state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.stop_btn)         state_d = ST_HOLD;
                else if (bus.wheel_pulse) state_d = ST_RUN;
            end
            ST_HOLD: begin
                if (bus.stop_btn)  state_d = ST_IDLE;
                else if (start_ev) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // No-motion seconds: only advances in RUN; a wheel pulse restarts it and
    // reaching the idle limit wraps it to zero as the block drops into WAIT.
    always_comb begin
        nm_d = nm_q;
        if (start_ev) begin
            nm_d = '0;
        end else if (state_q == ST_RUN) begin
            if (bus.wheel_pulse)  nm_d = '0;
            else if (nm_done)     nm_d = '0;
            else if (bus.sec_tick) nm_d = nm_q + 1'b1;
        end
    end

    always_comb begin
        trip_secs_d = trip_secs_q;
        if (start_ev) begin
            trip_secs_d = '0;
        end else if (in_trip && bus.sec_tick && (trip_secs_q != '1)) begin
            trip_secs_d = trip_secs_q + 1'b1;
        end
    end

    always_comb begin
        fare_clr_d = start_ev;
    end

    // The distance count survives RUN<->WAIT; the wait-second count is thrown
    // away both on entering WAIT and when motion resumes, so a wheel pulse that
    // coincides with a completing tick suppresses that wait unit.
    assign dist_en  = in_trip && bus.wheel_pulse;
    assign wait_en  = (state_q == ST_WAIT) && bus.sec_tick;
    assign wait_clr = start_ev ||
                      ((state_q == ST_RUN) && (state_d == ST_WAIT)) ||
                      ((state_q == ST_WAIT) && bus.wheel_pulse);

    mod_counter #(.N(PULSES_PER_UNIT)) u_dist_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (dist_en),
        .clr     (start_ev),
        .term_en (!bus.fare_max),
        .term    (dist_term)
    );

    mod_counter #(.N(WAIT_UNIT_SECS)) u_wait_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wait_en),
        .clr     (wait_clr),
        .term_en (!bus.fare_max),
        .term    (wait_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            nm_q        <= '0;
            trip_secs_q <= '0;
            fare_clr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nm_q        <= nm_d;
            trip_secs_q <= trip_secs_d;
            fare_clr_q  <= fare_clr_d;
        end
    end

    assign bus.state     = state_q;
    assign bus.fare_clr  = fare_clr_q;
    assign bus.dist_inc  = dist_term;
    assign bus.wait_inc  = wait_term;
    assign bus.trip_secs = trip_secs_q;

endmodule
